// File: rtl/p_hit_feeder_pkg.sv
// Shared types and constants for the p_hit input interface feeder.
package p_hit_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NUM_DEST   = 4;

  // Three signed components packed as {x, y, z}; x occupies the top slot.
  typedef logic signed [2:0][DATA_WIDTH-1:0] vec3_t;

  // Destination group indices into out_full / out_wr_en.
  localparam int unsigned DEST_0 = 0;  // tri_normal_1, v0, origin_1, dir_1
  localparam int unsigned DEST_1 = 1;  // tri_normal_2
  localparam int unsigned DEST_2 = 2;  // dir_2
  localparam int unsigned DEST_3 = 3;  // origin_2

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } feeder_state_t;

endpackage

// File: rtl/p_hit_feeder_stats.sv
// Record and stall counters for p_hit_feeder.
// Present only when P_HIT_FEEDER_STATS_EN is defined.
`ifdef P_HIT_FEEDER_STATS_EN
module p_hit_feeder_stats (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic        i_stall,
  output logic [31:0] o_record_count,
  output logic [31:0] o_stall_count
);

  logic [31:0] r_record_count;
  logic [31:0] r_stall_count;

  // Free-running counters; wrap naturally at 2^32.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_record_count <= '0;
      r_stall_count  <= '0;
    end else begin
      if (i_load)  r_record_count <= r_record_count + 32'd1;
      if (i_stall) r_stall_count  <= r_stall_count + 32'd1;
    end
  end

  assign o_record_count = r_record_count;
  assign o_stall_count  = r_stall_count;

endmodule
`endif

// File: rtl/p_hit_feeder.sv
// p_hit_feeder: pops one ray/triangle record from a show-ahead FIFO and
// delivers it exactly once to each of four destination FIFO groups, each
// destination independently of the others' backpressure.
// Optional statistics counters: define P_HIT_FEEDER_STATS_EN.
module p_hit_feeder
  import p_hit_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  vec3_t               in_tri_normal,
  input  vec3_t               in_v0,
  input  vec3_t               in_origin,
  input  vec3_t               in_dir,
  input  logic                in_empty,
  output logic                in_rd_en,
  output vec3_t               out_tri_normal,
  output vec3_t               out_v0,
  output vec3_t               out_origin,
  output vec3_t               out_dir,
  input  logic [NUM_DEST-1:0] out_full,
  output logic [NUM_DEST-1:0] out_wr_en
`ifdef P_HIT_FEEDER_STATS_EN
  ,
  output logic [31:0]         record_count,
  output logic [31:0]         stall_count
`endif
);

  if (NUM_DEST != 4) begin : g_num_dest_check
    $error("p_hit_feeder drives exactly four destination groups");
  end

  feeder_state_t       r_state;
  feeder_state_t       w_state_next;
  logic [NUM_DEST-1:0] r_pending;
  logic [NUM_DEST-1:0] w_pending_next;
  logic [NUM_DEST-1:0] w_wr_en;
  logic                w_done;
  logic                w_load;
  vec3_t               r_tri_normal;
  vec3_t               r_v0;
  vec3_t               r_origin;
  vec3_t               r_dir;

  // Strobe decode, completion detect, pop decision and next state.
  // Strobes and pop are forced low while reset is asserted.
  always_comb begin
    w_wr_en        = '0;
    w_done         = 1'b0;
    w_load         = 1'b0;
    w_state_next   = r_state;
    w_pending_next = r_pending;
    if (!reset) begin
      if (r_state == SEND) begin
        w_wr_en = r_pending & ~out_full;
        w_done  = ((r_pending & ~w_wr_en) == '0);
      end
      w_load = !in_empty && ((r_state == IDLE) || w_done);
    end
    if (w_load) begin
      w_pending_next = '1;
      w_state_next   = SEND;
    end else if (r_state == SEND) begin
      w_pending_next = r_pending & ~w_wr_en;
      if (w_done) w_state_next = IDLE;
    end
  end

  // State and per-destination pending mask.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
    end
  end

  // Held record: captured on pop, stable until the next pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tri_normal <= '0;
      r_v0         <= '0;
      r_origin     <= '0;
      r_dir        <= '0;
    end else if (w_load) begin
      r_tri_normal <= in_tri_normal;
      r_v0         <= in_v0;
      r_origin     <= in_origin;
      r_dir        <= in_dir;
    end
  end

  assign in_rd_en       = w_load;
  assign out_wr_en      = w_wr_en;
  assign out_tri_normal = r_tri_normal;
  assign out_v0         = r_v0;
  assign out_origin     = r_origin;
  assign out_dir        = r_dir;

`ifdef P_HIT_FEEDER_STATS_EN
  logic w_stall;

  // A stall cycle is any SEND cycle where some still-pending destination is full.
  always_comb begin
    w_stall = (r_state == SEND) && ((r_pending & out_full) != '0);
  end

  p_hit_feeder_stats u_stats (
    .i_clock        (clock),
    .i_reset        (reset),
    .i_load         (w_load),
    .i_stall        (w_stall),
    .o_record_count (record_count),
    .o_stall_count  (stall_count)
  );
`endif

endmodule

// File: tb/tb_p_hit_feeder.sv
// Self-checking bench for p_hit_feeder: upstream FIFO model, expected-write
// scoreboard and directed scenarios. Stats checks run when
// P_HIT_FEEDER_STATS_EN is defined.
module tb_p_hit_feeder;
  import p_hit_pkg::*;

  typedef struct packed {
    vec3_t tn;
    vec3_t v0;
    vec3_t org;
    vec3_t dir;
  } rec_t;

  typedef struct packed {
    logic [3:0] mask;
    rec_t       rec;
  } wr_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  vec3_t      in_tri_normal, in_v0, in_origin, in_dir;
  logic       in_empty;
  logic       in_rd_en;
  vec3_t      out_tri_normal, out_v0, out_origin, out_dir;
  logic [3:0] out_full = 4'b0000;
  logic [3:0] out_wr_en;
`ifdef P_HIT_FEEDER_STATS_EN
  logic [31:0] record_count, stall_count;
`endif

  int   total = 0;
  int   bad = 0;
  int   rd_pulses = 0;
  rec_t up_q[$];
  wr_t  exp_q[$];

  p_hit_feeder dut (
    .clock          (clock),
    .reset          (reset),
    .in_tri_normal  (in_tri_normal),
    .in_v0          (in_v0),
    .in_origin      (in_origin),
    .in_dir         (in_dir),
    .in_empty       (in_empty),
    .in_rd_en       (in_rd_en),
    .out_tri_normal (out_tri_normal),
    .out_v0         (out_v0),
    .out_origin     (out_origin),
    .out_dir        (out_dir),
    .out_full       (out_full),
    .out_wr_en      (out_wr_en)
`ifdef P_HIT_FEEDER_STATS_EN
    ,
    .record_count   (record_count),
    .stall_count    (stall_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic void chk(string name, logic [415:0] act, logic [415:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic rec_t mk(int k);
    rec_t r;
    r.tn  = {32'(k * 100 + 1), 32'(k * 100 + 2), 32'(k * 100 + 3)};
    r.v0  = {32'(-(k * 100 + 4)), 32'(k * 100 + 5), 32'(-(k * 100 + 6))};
    r.org = {32'(k * 100 + 7), 32'(-(k * 100 + 8)), 32'(k * 100 + 9)};
    r.dir = {32'(k * 1000), 32'(k * 1000 + 1), 32'(-(k * 1000 + 2))};
    return r;
  endfunction

  task automatic refresh_up();
    if (up_q.size() == 0) begin
      in_empty      = 1'b1;
      in_tri_normal = '0;
      in_v0         = '0;
      in_origin     = '0;
      in_dir        = '0;
    end else begin
      in_empty      = 1'b0;
      in_tri_normal = up_q[0].tn;
      in_v0         = up_q[0].v0;
      in_origin     = up_q[0].org;
      in_dir        = up_q[0].dir;
    end
  endtask

  task automatic expect_wr(logic [3:0] m, rec_t r);
    wr_t w;
    w.mask = m;
    w.rec  = r;
    exp_q.push_back(w);
  endtask

  // Upstream show-ahead FIFO: pop after each clock edge that saw in_rd_en.
  always @(posedge clock) begin
    if (in_rd_en) begin
      #1;
      if (up_q.size() == 0) begin
        chk("pop_on_empty", 1, 0);
      end else begin
        void'(up_q.pop_front());
        rd_pulses++;
      end
      refresh_up();
    end
  end

  // Scoreboard monitor: every strobe cycle must match the next expected write.
  always @(negedge clock) begin
    wr_t got;
    if (out_wr_en !== 4'b0000) begin
      got.mask    = out_wr_en;
      got.rec.tn  = out_tri_normal;
      got.rec.v0  = out_v0;
      got.rec.org = out_origin;
      got.rec.dir = out_dir;
      if (exp_q.size() == 0) chk("unexpected_write", got, '0);
      else                   chk("write", got, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t r, r2;
    int   n0, p0;
    logic [31:0] rc0, sc0;
    rc0 = '0;
    sc0 = '0;
    refresh_up();

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_wr_en", out_wr_en, 4'b0000);
    chk("rst_rd_en", in_rd_en, 1'b0);
    chk("rst_origin", out_origin, '0);
    chk("rst_tri_normal", out_tri_normal, '0);
`ifdef P_HIT_FEEDER_STATS_EN
    chk("rst_record_count", record_count, 32'd0);
    chk("rst_stall_count", stall_count, 32'd0);
`endif
    @(posedge clock); #2;
    reset = 1'b0;

    // 1. Single record
    @(posedge clock); #2;
    r = mk(1);
    r.org = {32'd1 << 16, 32'd2 << 16, 32'd3 << 16};
    up_q.push_back(r);
    refresh_up();
    expect_wr(4'b1111, r);
    @(negedge clock);
    chk("s1_rd_en", in_rd_en, 1'b1);
    chk("s1_no_wr_yet", out_wr_en, 4'b0000);
    @(negedge clock);
    chk("s1_wr_en", out_wr_en, 4'b1111);
    chk("s1_origin", out_origin, {32'd65536, 32'd131072, 32'd196608});
    chk("s1_rd_after", in_rd_en, 1'b0);
    @(negedge clock);
    chk("s1_idle_wr", out_wr_en, 4'b0000);
    chk("s1_pops", rd_pulses, 1);

    // 2. Back-to-back
    @(posedge clock); #2;
    for (int k = 2; k <= 4; k++) begin
      up_q.push_back(mk(k));
      expect_wr(4'b1111, mk(k));
    end
    refresh_up();
    @(negedge clock);
    chk("s2_rd_0", in_rd_en, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      chk("s2_wr_en", out_wr_en, 4'b1111);
      chk("s2_rd_en", in_rd_en, (i < 3) ? 1'b1 : 1'b0);
    end
    @(negedge clock);
    chk("s2_idle_wr", out_wr_en, 4'b0000);
    chk("s2_pops", rd_pulses, 4);

    // 3. Partial stall on destination 2
    @(posedge clock); #2;
    out_full = 4'b0100;
    r  = mk(5);
    r2 = mk(6);
    up_q.push_back(r);
    up_q.push_back(r2);
    refresh_up();
    expect_wr(4'b1011, r);
    expect_wr(4'b0100, r);
    expect_wr(4'b1111, r2);
`ifdef P_HIT_FEEDER_STATS_EN
    rc0 = record_count;
    sc0 = stall_count;
`endif
    @(negedge clock);
    chk("s3_rd_0", in_rd_en, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      chk("s3_wr_en", out_wr_en, (i == 1) ? 4'b1011 : 4'b0000);
      chk("s3_rd_held", in_rd_en, 1'b0);
    end
    @(posedge clock); #2;
    out_full = 4'b0000;
    @(negedge clock);
    chk("s3_wr_late", out_wr_en, 4'b0100);
    chk("s3_rd_next", in_rd_en, 1'b1);
`ifdef P_HIT_FEEDER_STATS_EN
    chk("s3_record_count", record_count - rc0, 32'd1);
    chk("s3_stall_count", stall_count - sc0, 32'd5);
`endif
    @(negedge clock);
    chk("s3_wr_next", out_wr_en, 4'b1111);
    @(negedge clock);
    chk("s3_idle_wr", out_wr_en, 4'b0000);
    chk("s3_pops", rd_pulses, 6);

    // 4. Reset while destination 2 is still pending
    @(posedge clock); #2;
    out_full = 4'b0100;
    r  = mk(7);
    r2 = mk(8);
    up_q.push_back(r);
    up_q.push_back(r2);
    refresh_up();
    expect_wr(4'b1011, r);
    @(negedge clock);
    chk("s4_rd_0", in_rd_en, 1'b1);
    @(negedge clock);
    chk("s4_wr_partial", out_wr_en, 4'b1011);
    @(posedge clock); #2;
    n0 = up_q.size();
    p0 = rd_pulses;
    reset = 1'b1;
    #1;
    chk("s4_wr_in_reset", out_wr_en, 4'b0000);
    chk("s4_rd_in_reset", in_rd_en, 1'b0);
    chk("s4_origin_cleared", out_origin, '0);
    @(negedge clock);
    chk("s4_wr_hold", out_wr_en, 4'b0000);
    @(posedge clock); #2;
    chk("s4_fifo_count", up_q.size(), n0);
    chk("s4_pops_frozen", rd_pulses, p0);
    out_full = 4'b0000;
    reset = 1'b0;
    expect_wr(4'b1111, r2);
    @(negedge clock);
    chk("s4_rd_after", in_rd_en, 1'b1);
    chk("s4_no_stale_wr", out_wr_en, 4'b0000);
    @(negedge clock);
    chk("s4_wr_new", out_wr_en, 4'b1111);
    @(negedge clock);
    chk("s4_idle_wr", out_wr_en, 4'b0000);

    // 5. Upstream starve after one record, with a brief stall on dest 0
    @(posedge clock); #2;
    out_full = 4'b0001;
    r = mk(9);
    up_q.push_back(r);
    refresh_up();
    expect_wr(4'b1110, r);
    expect_wr(4'b0001, r);
    @(negedge clock);
    chk("s5_rd_0", in_rd_en, 1'b1);
    @(negedge clock);
    chk("s5_wr_1", out_wr_en, 4'b1110);
    @(posedge clock); #2;
    out_full = 4'b0000;
    @(negedge clock);
    chk("s5_wr_2", out_wr_en, 4'b0001);
    chk("s5_rd_empty", in_rd_en, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("s5_quiet_wr", out_wr_en, 4'b0000);
      chk("s5_quiet_rd", in_rd_en, 1'b0);
    end
    chk("s5_pops", rd_pulses, 9);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
